misc_adder_scheduler: RTL and testbench

MISC_ADDER_SCHEDULER -- requirements
Module: misc_adder_scheduler

---
 rtl/misc_adder_scheduler.sv | 102 ++++++++++
 tb/tb_misc_adder_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/misc_adder_scheduler.sv
// Two-requester round-robin adder: accepts one operand pair at a time, waits
// PIPE_LAT cycles, then presents a + b + SUM_BIAS until the consumer takes it.
module misc_adder_scheduler #(
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned SUM_BIAS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        busy,
  output logic [7:0]  done_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;

  localparam logic [3:0]  CNT_INIT = 4'(PIPE_LAT - 1);
  localparam logic [15:0] BIAS16   = 16'(SUM_BIAS);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_id;
  logic        r_last_grant;
  logic [15:0] r_sum;
  logic [7:0]  r_done_cnt;

  logic w_idle;
  logic w_grant;
  logic w_accept;

  // Grant only matters in IDLE; a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_idle = (r_state == S_IDLE) && !rst;
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
    else                          w_grant = req1_valid;
    w_accept = w_idle && (req0_valid || req1_valid);
  end

  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid &&  w_grant;
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign rsp_id     = r_id;
  assign rsp_sum    = r_sum;
  assign done_cnt   = r_done_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_sum        <= '0;
      r_done_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant ? req1_a : req0_a;
            r_b          <= w_grant ? req1_b : req0_b;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= CNT_INIT;
            r_state      <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (r_cnt == 4'd0) begin
            r_sum   <= {8'b0, r_a} + {8'b0, r_b} + BIAS16;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_done_cnt <= r_done_cnt + 8'd1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misc_adder_scheduler.sv
// Directed bench for misc_adder_scheduler: default instance plus a SUM_BIAS=65535
// instance sharing the same stimulus to exercise 16-bit sum truncation.
module tb_misc_adder_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [15:0] rsp_sum;
  logic [7:0]  done_cnt;
  logic        b_r0, b_r1, b_valid, b_id, b_busy;
  logic [15:0] b_sum;
  logic [7:0]  b_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  misc_adder_scheduler #(.PIPE_LAT(2), .SUM_BIAS(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .done_cnt(done_cnt)
  );

  misc_adder_scheduler #(.PIPE_LAT(2), .SUM_BIAS(65535)) dut_bias (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(b_r1),
    .rsp_valid(b_valid), .rsp_ready(rsp_ready), .rsp_id(b_id), .rsp_sum(b_sum),
    .busy(b_busy), .done_cnt(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
    tick(); tick();
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);

    // Single request 3 + 4 + 10 = 17
    rst = 1'b0; req1_valid = 1'b0; req0_a = 8'd3; req0_b = 8'd4; rsp_ready = 1'b1;
    #1;
    chk("single_ready0", 32'(req0_ready), 32'd1);
    chk("single_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req0_a = 8'hAA; req0_b = 8'h55;
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_v_e0", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_v_e1", 32'(rsp_valid), 32'd0);
    tick();
    chk("single_v_e2", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_sum", 32'(rsp_sum), 32'd17);
    chk("single_done_e2", 32'(done_cnt), 32'd0);
    tick();
    chk("single_v_e3", 32'(rsp_valid), 32'd0);
    chk("single_done_e3", 32'(done_cnt), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Round robin after reset: 0,1,0,1, accepts every 4 cycles
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_a = 8'd10; req0_b = 8'd20; req1_a = 8'd100; req1_b = 8'd200;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ready1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      for (int j = 0; j < 3; j++) begin
        chk("rr_hold0", 32'(req0_ready), 32'd0);
        chk("rr_hold1", 32'(req1_ready), 32'd0);
        if (j == 2) begin
          chk("rr_valid", 32'(rsp_valid), 32'd1);
          chk("rr_id", 32'(rsp_id), 32'(k % 2));
          chk("rr_sum", 32'(rsp_sum), (k % 2 == 0) ? 32'd40 : 32'd310);
        end
        tick();
      end
    end
    chk("rr_done", 32'(done_cnt), 32'd4);

    // Backpressure with max operands
    req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 8'd255; req0_b = 8'd255; rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 8'd1; req1_b = 8'd2;
    tick(); tick();
    chk("bp_bias_ctl", {20'd0, b_r0, b_r1, b_valid, b_id, b_busy, 3'd0, b_done[3:0]},
        {20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 4'd4});
    chk("bp_bias_sum", 32'(b_sum), 32'h01FD);
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_sum", 32'(rsp_sum), 32'h0208);
      chk("bp_ready1", 32'(req1_ready), 32'd0);
      chk("bp_done", 32'(done_cnt), 32'd4);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready1_last", 32'(req1_ready), 32'd0);
    tick();
    chk("bp_cmpl_valid", 32'(rsp_valid), 32'd0);
    chk("bp_cmpl_done", 32'(done_cnt), 32'd5);
    chk("bp_ready1_idle", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("idle_rspready_done", 32'(done_cnt), 32'd5);
    tick();
    chk("r1_id", 32'(rsp_id), 32'd1);
    chk("r1_sum", 32'(rsp_sum), 32'd13);
    tick();
    chk("r1_done", 32'(done_cnt), 32'd6);

    // Reset during COMPUTE aborts the transaction
    req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd5;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done_cnt), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    tick(); tick();
    chk("abort_valid_late", 32'(rsp_valid), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("abort_tie0", 32'(req0_ready), 32'd1);
    chk("abort_tie1", 32'(req1_ready), 32'd0);

    // 256 completions wrap done_cnt
    req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int n = 0; n < 255 * 4; n++) tick();
    chk("wrap_255", 32'(done_cnt), 32'd255);
    for (int n = 0; n < 4; n++) tick();
    chk("wrap_0", 32'(done_cnt), 32'd0);
    req0_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
